// File: rtl/game_flow_ctrl.sv
// Game-flow controller: sequences levels through intro/play/respawn/win/lose
// and keeps lives, a saturating score and the session high score.
module game_flow_ctrl #(
    parameter int NUM_LEVELS   = 2,
    parameter int LIVES        = 3,
    parameter int SCORE_W      = 8,
    parameter int KILL_PTS     = 1,
    parameter int INTRO_CYCLES = 100000000
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            kill,
    input  logic                            tank_hit,
    input  logic                            level_clear,
    output logic [$clog2(NUM_LEVELS+1)-1:0] level,
    output logic                            level_init,
    output logic                            play_en,
    output logic [$clog2(LIVES+1)-1:0]      lives,
    output logic [SCORE_W-1:0]              score,
    output logic [SCORE_W-1:0]              hi_score,
    output logic [5:0]                      state
);

    localparam int LVL_W = $clog2(NUM_LEVELS + 1);
    localparam int LIV_W = $clog2(LIVES + 1);
    localparam int CNT_W = $clog2(INTRO_CYCLES);

    localparam logic [5:0] S_IDLE    = 6'b000001;
    localparam logic [5:0] S_INTRO   = 6'b000010;
    localparam logic [5:0] S_PLAY    = 6'b000100;
    localparam logic [5:0] S_RESPAWN = 6'b001000;
    localparam logic [5:0] S_WIN     = 6'b010000;
    localparam logic [5:0] S_LOSE    = 6'b100000;

    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(INTRO_CYCLES - 1);
    localparam logic [LVL_W-1:0]   LVL_FIRST  = LVL_W'(1);
    localparam logic [LVL_W-1:0]   LVL_LAST   = LVL_W'(NUM_LEVELS);
    localparam logic [LIV_W-1:0]   LIVES_INIT = LIV_W'(LIVES);
    localparam logic [LIV_W-1:0]   LIVES_ONE  = LIV_W'(1);
    localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;

    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [5:0]         state_n;
    logic [LVL_W-1:0]   level_n;
    logic [LIV_W-1:0]   lives_n;
    logic [SCORE_W-1:0] score_n, hi_n, score_sat;
    logic               level_init_n, play_en_n;

    // Headroom compared in 32 bits so KILL_PTS wider than the score still saturates.
    always_comb begin
        if (32'(SCORE_MAX) - 32'(score) <= 32'(KILL_PTS))
            score_sat = SCORE_MAX;
        else
            score_sat = score + SCORE_W'(KILL_PTS);
    end

    always_comb begin
        state_n = state;
        level_n = level;
        lives_n = lives;
        score_n = score;
        hi_n    = hi_score;
        cnt_n   = cnt;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = S_INTRO;
                    level_n = LVL_FIRST;
                    lives_n = LIVES_INIT;
                    score_n = '0;
                end
            end
            S_INTRO, S_RESPAWN: begin
                if (cnt == CNT_LAST) begin
                    state_n = S_PLAY;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_PLAY: begin
                if (kill)
                    score_n = score_sat;
                if (level_clear) begin
                    if (level < LVL_LAST) begin
                        level_n = level + 1'b1;
                        state_n = S_INTRO;
                    end else begin
                        state_n = S_WIN;
                    end
                end else if (tank_hit) begin
                    if (lives > LIVES_ONE) begin
                        lives_n = lives - 1'b1;
                        state_n = S_RESPAWN;
                    end else begin
                        lives_n = '0;
                        state_n = S_LOSE;
                    end
                end
                // A kill on the final edge of play counts toward the high score.
                if ((state_n == S_WIN || state_n == S_LOSE) && score_n > hi_score)
                    hi_n = score_n;
            end
            S_WIN, S_LOSE: begin
                if (start) begin
                    state_n = S_IDLE;
                    level_n = '0;
                end
            end
            default: begin
                state_n = S_IDLE;
                level_n = '0;
                cnt_n   = '0;
            end
        endcase
    end

    assign level_init_n = (state_n == S_INTRO) && (state != S_INTRO);
    assign play_en_n    = (state_n == S_PLAY);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            level      <= '0;
            level_init <= 1'b0;
            play_en    <= 1'b0;
            lives      <= LIVES_INIT;
            score      <= '0;
            hi_score   <= '0;
            cnt        <= '0;
        end else begin
            state      <= state_n;
            level      <= level_n;
            level_init <= level_init_n;
            play_en    <= play_en_n;
            lives      <= lives_n;
            score      <= score_n;
            hi_score   <= hi_n;
            cnt        <= cnt_n;
        end
    end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Bench for game_flow_ctrl: phase-level reference model checked every cycle,
// plus literal expectations along a directed game script.
module tb_game_flow_ctrl;
    localparam int NL = 3, LV = 2, SW = 4, KP = 5, IC = 4;
    localparam int SMAX = (1 << SW) - 1;
    localparam int P_IDLE = 0, P_INTRO = 1, P_PLAY = 2, P_RESP = 3, P_WIN = 4, P_LOSE = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0, kill = 1'b0, tank_hit = 1'b0, level_clear = 1'b0;
    logic [1:0]    level;
    logic          level_init, play_en;
    logic [1:0]    lives;
    logic [SW-1:0] score, hi_score;
    logic [5:0]    state;

    int checks = 0;
    int errors = 0;

    game_flow_ctrl #(.NUM_LEVELS(NL), .LIVES(LV), .SCORE_W(SW), .KILL_PTS(KP), .INTRO_CYCLES(IC)) dut (
        .clk(clk), .rst(rst), .start(start), .kill(kill), .tank_hit(tank_hit),
        .level_clear(level_clear), .level(level), .level_init(level_init), .play_en(play_en),
        .lives(lives), .score(score), .hi_score(hi_score), .state(state)
    );

    always #5 clk = ~clk;

    // Reference model: phase plus remaining pause cycles.
    int m_ph = P_IDLE, m_left = 0, m_lvl = 0, m_liv = LV, m_sc = 0, m_hi = 0, m_init = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ph = P_IDLE; m_left = 0; m_lvl = 0; m_liv = LV; m_sc = 0; m_hi = 0; m_init = 0;
        end else begin
            m_init = 0;
            case (m_ph)
                P_IDLE: if (start) begin
                    m_ph = P_INTRO; m_left = IC; m_lvl = 1; m_liv = LV; m_sc = 0; m_init = 1;
                end
                P_INTRO, P_RESP: begin
                    m_left--;
                    if (m_left == 0) m_ph = P_PLAY;
                end
                P_PLAY: begin
                    if (kill) m_sc = (m_sc + KP > SMAX) ? SMAX : m_sc + KP;
                    if (level_clear && m_lvl < NL) begin
                        m_lvl++; m_ph = P_INTRO; m_left = IC; m_init = 1;
                    end else if (level_clear) m_ph = P_WIN;
                    else if (tank_hit) begin
                        m_liv--;
                        if (m_liv > 0) begin m_ph = P_RESP; m_left = IC; end
                        else m_ph = P_LOSE;
                    end
                    if ((m_ph == P_WIN || m_ph == P_LOSE) && m_sc > m_hi) m_hi = m_sc;
                end
                default: if (start) begin m_ph = P_IDLE; m_lvl = 0; end
            endcase
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("m_state", int'(state), 1 << m_ph);
        chk("m_level", int'(level), m_lvl);
        chk("m_level_init", int'(level_init), m_init);
        chk("m_play_en", int'(play_en), int'(m_ph == P_PLAY));
        chk("m_lives", int'(lives), m_liv);
        chk("m_score", int'(score), m_sc);
        chk("m_hi_score", int'(hi_score), m_hi);
    end

    task automatic cyc(input logic s, input logic k, input logic t, input logic lc);
        start = s; kill = k; tank_hit = t; level_clear = lc;
        @(posedge clk); #1;
        start = 0; kill = 0; tank_hit = 0; level_clear = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(0, 0, 0, 0);
    endtask

    initial begin
        #17;
        chk("rst_state", int'(state), 1);
        chk("rst_lives", int'(lives), 2);
        chk("rst_level", int'(level), 0);
        rst = 0;
        #5;
        // Events outside PLAY are ignored
        cyc(0, 1, 1, 1);
        // 1: start -> INTRO level 1
        cyc(1, 0, 0, 0);
        @(negedge clk);
        chk("intro_state", int'(state), 2);
        chk("intro_level", int'(level), 1);
        chk("intro_init", int'(level_init), 1);
        idle(3);
        chk("intro_4th_cycle", int'(state), 2);
        chk("intro_init_gone", int'(level_init), 0);
        idle(1);
        chk("play_state", int'(state), 4);
        chk("play_en", int'(play_en), 1);
        // 2: full win
        cyc(0, 1, 0, 0); cyc(0, 1, 0, 0);
        chk("score_10", int'(score), 10);
        cyc(0, 0, 0, 1);
        chk("lvl2", int'(level), 2);
        chk("lvl2_init", int'(level_init), 1);
        idle(4);
        cyc(0, 0, 0, 1);
        chk("lvl3", int'(level), 3);
        idle(4);
        cyc(0, 0, 0, 1);
        chk("win_state", int'(state), 16);
        chk("win_hi", int'(hi_score), 10);
        cyc(1, 0, 0, 0);
        chk("win_to_idle", int'(state), 1);
        chk("idle_level", int'(level), 0);
        cyc(1, 0, 0, 0);
        chk("new_score", int'(score), 0);
        chk("hi_kept", int'(hi_score), 10);
        idle(4);
        // 3: saturation
        repeat (4) cyc(0, 1, 0, 0);
        chk("score_sat", int'(score), 15);
        // 5: simultaneous clear + hit, then junk during INTRO
        cyc(0, 0, 1, 1);
        chk("simul_level", int'(level), 2);
        chk("simul_lives", int'(lives), 2);
        cyc(1, 1, 1, 0);
        idle(2);
        chk("intro_unaffected", int'(state), 2);
        chk("intro_score", int'(score), 15);
        idle(1);
        chk("play_again", int'(state), 4);
        // 4: lives
        cyc(0, 0, 1, 0);
        chk("resp_state", int'(state), 8);
        chk("resp_lives", int'(lives), 1);
        chk("resp_no_init", int'(level_init), 0);
        chk("resp_play_en", int'(play_en), 0);
        idle(3);
        chk("resp_level", int'(level), 2);
        idle(1);
        chk("resp_done", int'(state), 4);
        cyc(0, 1, 1, 0);
        chk("lose_state", int'(state), 32);
        chk("lose_lives", int'(lives), 0);
        chk("lose_hi", int'(hi_score), 15);
        cyc(1, 0, 0, 0);
        chk("lose_to_idle", int'(state), 1);
        cyc(1, 0, 0, 0);
        chk("restart_score", int'(score), 0);
        chk("restart_hi", int'(hi_score), 15);
        chk("restart_lives", int'(lives), 2);
        // 6: reset mid-PLAY
        idle(4);
        cyc(0, 1, 0, 0); cyc(0, 1, 0, 0);
        chk("pre_rst_score", int'(score), 10);
        rst = 1;
        #1;
        chk("arst_state", int'(state), 1);
        chk("arst_score", int'(score), 0);
        chk("arst_hi", int'(hi_score), 0);
        chk("arst_play_en", int'(play_en), 0);
        chk("arst_lives", int'(lives), 2);
        @(posedge clk); #3;
        rst = 0;
        idle(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
